serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADDER_SUB_EN to add port sub, which selects a - b - cin (borrow chain).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             ack,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              cell_s;
    logic              cell_c;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;

    // Difference bit equals sum bit; only the carry/borrow chain differs.
    always_comb begin
        cell_s = a_q[0] ^ b_q[0] ^ carry_q;
        if (sub_q) begin
            cell_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & carry_q);
        end else begin
            cell_c = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
        end
    end
`else
    always_comb begin
        cell_s = a_q[0] ^ b_q[0] ^ carry_q;
        cell_c = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {cell_s, sum_q[WIDTH-1:1]};
                carry_d = cell_c;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    assign sum   = sum_q;
    assign cout  = carry_q;
    assign valid = (state_q == StDone);
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a randomized regression
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NRAND = 3000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             ack = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             valid;
    logic             busy;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ack   (ack),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                         input logic mc, input logic msub,
                         output logic [WIDTH-1:0] esum, output logic ecout);
        longint ia, ib, ic, r;
        ia = longint'(ma);
        ib = longint'(mb);
        ic = longint'(mc);
        if (msub) begin
            r     = ia - ib - ic;
            esum  = WIDTH'(r);
            ecout = (ia < ib + ic);
        end else begin
            r     = ia + ib + ic;
            esum  = WIDTH'(r);
            ecout = r[WIDTH];
        end
    endtask

    // One full transaction; inputs change #1 after posedge, outputs sampled there too.
    task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                          input logic oc, input logic osub, input int hold,
                          input logic poke, input string tag);
        logic [WIDTH-1:0] esum;
        logic             ecout;
        model(oa, ob, oc, osub, esum, ecout);
        a = oa; b = ob; cin = oc; sub = osub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".accept_busy"}, 32'(busy), 32'd1);
        check({tag, ".accept_valid"}, 32'(valid), 32'd0);
        for (int i = 1; i < int'(WIDTH); i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            sub = 1'($urandom);
            if (poke && i == 3) start = 1'b1;
            ack = 1'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            ack = 1'b0;
            check({tag, ".run_valid"}, 32'(valid), 32'd0);
            check({tag, ".run_busy"}, 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        check({tag, ".done_valid"}, 32'(valid), 32'd1);
        check({tag, ".done_busy"}, 32'(busy), 32'd1);
        check({tag, ".sum"}, 32'(sum), 32'(esum));
        check({tag, ".cout"}, 32'(cout), 32'(ecout));
        for (int d = 0; d < hold; d++) begin
            start = poke ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(valid), 32'd1);
            check({tag, ".hold_sum"}, 32'({cout, sum}), 32'({ecout, esum}));
        end
        ack = 1'b1;
        start = poke;
        @(posedge clk); #1;
        ack = 1'b0;
        start = 1'b0;
        check({tag, ".ack_valid"}, 32'(valid), 32'd0);
        check({tag, ".ack_busy"}, 32'(busy), 32'd0);
        check({tag, ".ack_retain"}, 32'({cout, sum}), 32'({ecout, esum}));
        if (poke) begin
            @(posedge clk); #1;
            check({tag, ".no_queue"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic sub_ok;
`ifdef SERIAL_ADDER_SUB_EN
        sub_ok = 1'b1;
`else
        sub_ok = 1'b0;
`endif
        #12;
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.cout", 32'(cout), 32'd0);
        check("reset.valid", 32'(valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        // Release mid-cycle; the next start lands on the first rising edge.
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, "wrap");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1, 1'b0, "max");
        run_op(8'hA5, 8'h0F, 1'b1, 1'b0, 5, 1'b1, "ignore_start");

        // Abort mid-run: outputs must clear without a clock edge.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort.sum", 32'(sum), 32'd0);
        check("abort.cout", 32'(cout), 32'd0);
        check("abort.valid", 32'(valid), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #2;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0, "post_reset");

        if (sub_ok) begin
            run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0, "sub_pos");
            run_op(8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0, "sub_neg");
            run_op(8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b0, "sub_borrow_in");
        end

        for (int n = 0; n < int'(NRAND); n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   sub_ok & 1'($urandom), int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck DUT still reaches a verdict.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
